// File: rtl/alu_md_pkg.sv
// Shared definitions for the alu_md EX-stage ALU: operation codes, the
// multiply/divide FSM encoding and small decode helpers.
package alu_md_pkg;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SLTU  = 4'd3;
  localparam logic [3:0] ALU_MULT  = 4'd4;
  localparam logic [3:0] ALU_MULTU = 4'd5;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_DIV   = 4'd8;
  localparam logic [3:0] ALU_DIVU  = 4'd9;
  localparam logic [3:0] ALU_MFHI  = 4'd10;
  localparam logic [3:0] ALU_MFLO  = 4'd11;
  localparam logic [3:0] ALU_NOR   = 4'd12;
  localparam logic [3:0] ALU_XOR   = 4'd13;
  localparam logic [3:0] ALU_MTHI  = 4'd14;
  localparam logic [3:0] ALU_MTLO  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // Codes that launch the iterative multiply/divide unit.
  function automatic logic is_md_ctl(input logic [3:0] ctl);
    return (ctl == ALU_MULT) || (ctl == ALU_MULTU) ||
           (ctl == ALU_DIV)  || (ctl == ALU_DIVU);
  endfunction

  // Codes that touch HI/LO and therefore must wait for the unit to drain.
  function automatic logic is_hilo_ctl(input logic [3:0] ctl);
    return is_md_ctl(ctl) || (ctl == ALU_MFHI) || (ctl == ALU_MFLO) ||
           (ctl == ALU_MTHI) || (ctl == ALU_MTLO);
  endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative radix-2 multiply/divide engine (md_iter). Magnitudes are latched
// on start, WIDTH shift-add or restoring-divide steps run in RUN, and FIX
// applies sign correction while presenting the HI/LO write.
// Optional: ALU_MD_EARLY_OUT_EN lets multiplies leave RUN as soon as the
// remaining multiplier bits are zero.
module md_iter
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             wr_en,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int W2 = 2 * WIDTH;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;     // operation is a divide
  logic             neg_q, neg_d;     // product / quotient must be negated
  logic             rneg_q, rneg_d;   // remainder must be negated
  logic             dz_q, dz_d;       // divisor was zero
  logic             done_q, done_d;
  // acc: product accumulator (mult) or partial remainder in the low half (div).
  // sh : shifted multiplicand (mult) or divisor in the low half (div).
  // op : remaining multiplier bits (mult) or dividend-in / quotient-out (div).
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    sh_q, sh_d;
  logic [WIDTH-1:0] op_q, op_d;

  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;
  logic [W2-1:0]    prod;
  logic             last_step;

  // Operand magnitudes and signs presented at start.
  always_comb begin
    sa    = op_signed & a[WIDTH-1];
    sb    = op_signed & b[WIDTH-1];
    abs_a = sa ? -a : a;
    abs_b = sb ? -b : b;
  end

  // Final RUN step: counter exhausted, or (optionally) no multiplier bits left.
`ifdef ALU_MD_EARLY_OUT_EN
  assign last_step = (cnt_q == CNT_W'(1)) || (!div_q && (op_q[WIDTH-1:1] == '0));
`else
  assign last_step = (cnt_q == CNT_W'(1));
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked blocks use <= so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_d unassigned and infers a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy  = (state_q != IDLE);
    wr_en = (state_q == FIX);
  end

  assign done = done_q;

  // Datapath next values: latch on start, one radix-2 step per RUN cycle.
  always_comb begin
    acc_d  = acc_q;
    sh_d   = sh_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    done_d = (state_q == FIX);
    // Restoring divide: shift next dividend bit into the partial remainder.
    rem_sh  = {acc_q[WIDTH-1:0], op_q[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, sh_q[WIDTH-1:0]});
    rem_sub = rem_sh[WIDTH-1:0] - sh_q[WIDTH-1:0];
    case (state_q)
      IDLE: begin
        if (start) begin
          div_d  = op_div;
          neg_d  = sa ^ sb;
          rneg_d = sa;
          dz_d   = (b == '0);
          cnt_d  = CNT_W'(WIDTH);
          acc_d  = '0;
          sh_d   = {{WIDTH{1'b0}}, (op_div ? abs_b : abs_a)};
          op_d   = op_div ? abs_a : abs_b;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (div_q) begin
          acc_d = {{WIDTH{1'b0}}, (rem_ge ? rem_sub : rem_sh[WIDTH-1:0])};
          op_d  = {op_q[WIDTH-2:0], rem_ge};
        end else begin
          if (op_q[0]) acc_d = acc_q + sh_q;
          sh_d = sh_q << 1;
          op_d = op_q >> 1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      sh_q   <= '0;
      op_q   <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      done_q <= done_d;
    end
  end

  // Sign-corrected results, consumed by the HI/LO registers while in FIX.
  // A zero divisor yields all-ones quotient regardless of signs; the
  // remainder already equals |a| and its sign fix restores a.
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    if (div_q) begin
      lo_res = dz_q ? '1 : (neg_q ? -op_q : op_q);
      hi_res = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end else begin
      hi_res = prod[W2-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU with single-cycle integer ops, signed overflow flag, and an
// iterative multiply/divide unit owning the architectural HI/LO registers.
// Optional: ALU_MD_EARLY_OUT_EN (early multiply termination inside md_iter).
module alu_md #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             oflow,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  import alu_md_pkg::*;

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic             md_wr, md_start, md_div, md_signed;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   diff;
  logic             oflow_add, oflow_sub, slt;

  // Launch decode for the multiply/divide unit.
  always_comb begin
    md_start  = valid && !busy && is_md_ctl(ctl);
    md_div    = (ctl == ALU_DIV) || (ctl == ALU_DIVU);
    md_signed = (ctl == ALU_MULT) || (ctl == ALU_DIV);
  end

  md_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_md_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (md_start),
    .op_div    (md_div),
    .op_signed (md_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .wr_en     (md_wr),
    .hi_res    (md_hi),
    .lo_res    (md_lo)
  );

  // Combinational ALU: result, overflow flag and zero detect.
  // slt is the true signed compare: difference sign, replaced by a's sign
  // whenever the subtraction overflowed.
  always_comb begin
    sum       = a + b;
    diff      = {1'b0, a} - {1'b0, b};
    oflow_add = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    oflow_sub = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
    slt       = oflow_sub ? a[MSB] : diff[MSB];
    out       = '0;
    oflow     = 1'b0;
    case (ctl)
      ALU_AND:  out = a & b;
      ALU_OR:   out = a | b;
      ALU_ADD:  begin out = sum;              oflow = oflow_add; end
      ALU_SUB:  begin out = diff[WIDTH-1:0];  oflow = oflow_sub; end
      ALU_SLT:  out = {{(WIDTH-1){1'b0}}, slt};
      ALU_SLTU: out = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      ALU_NOR:  out = ~(a | b);
      ALU_XOR:  out = a ^ b;
      ALU_MFHI: out = hi_q;
      ALU_MFLO: out = lo_q;
      default:  out = '0;
    endcase
    zero = (out == '0);
  end

  // Hold EX while a HI/LO-dependent op meets a running multiply/divide.
  assign stall = valid && busy && is_hilo_ctl(ctl);

  // HI/LO next value: unit writeback in FIX, else mthi/mtlo when idle.
  // The unit only writes while busy and moves require !busy, so they never collide.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (md_wr) begin
      hi_d = md_hi;
      lo_d = md_lo;
    end else if (valid && !busy) begin
      if (ctl == ALU_MTHI) hi_d = a;
      if (ctl == ALU_MTLO) lo_d = a;
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: HI/LO are architectural state and are cleared by reset, including an abort mid-operation.
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule
